// File: rtl/spi_cfg_master_pkg.sv
// spi_cfg_pkg: frame geometry, FSM states and PWM register map shared with the memory manager
package spi_cfg_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_e;
  localparam int FRAME_BITS = 40;
  localparam int CMD_BITS = 8;
  localparam int RW_BIT = 7;
  localparam int DATA_BITS = FRAME_BITS - CMD_BITS;
  localparam logic [CMD_BITS-2:0] REG_COUNTER = 7'h00;
  localparam logic [CMD_BITS-2:0] REG_PRESCALER = 7'h01;
  localparam logic [CMD_BITS-2:0] REG_DUTY = 7'h02;
  localparam logic [CMD_BITS-2:0] REG_ENABLE = 7'h03;
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic rw, input logic [CMD_BITS-2:0] addr,
                                                        input logic [DATA_BITS-1:0] wdata);
    logic [CMD_BITS-1:0] cmd;
    cmd = {1'b0, addr};
    cmd[RW_BIT] = rw;
    return {cmd, rw ? {DATA_BITS{1'b0}} : wdata};
  endfunction
endpackage

// File: rtl/spi_cfg_master_if.sv
// spi_cfg_master_if: local request/done handshake plus the four SPI pins
interface spi_cfg_master_if;
  import spi_cfg_pkg::*;
  logic start, rw, busy, done, err, sclk, mosi, cs_n, miso;
  logic [CMD_BITS-2:0] addr;
  logic [DATA_BITS-1:0] wdata, rdata;
  modport master(input start, rw, addr, wdata, miso, output busy, done, err, rdata, sclk, mosi, cs_n);
  modport slave(output start, rw, addr, wdata, miso, input busy, done, err, rdata, sclk, mosi, cs_n);
endinterface

// File: rtl/spi_cfg_master_clkgen.sv
// spi_cfg_clkgen: half-period down-counter, tick marks the last cycle of every CLK_DIV-cycle phase
module spi_cfg_clkgen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);
  localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);
  logic [7:0] cnt;
  assign tick = cnt == 8'd0;
  // restart aligns the phase grid to the accepted request, otherwise count down and wrap
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= RELOAD;
    else cnt <= (restart || tick) ? RELOAD : cnt - 8'd1;
endmodule

// File: rtl/spi_cfg_master.sv
// spi_cfg_master: SPI mode-0 master for 40-bit register frames; read capture enabled by SPI_CFG_MASTER_READBACK_EN
module spi_cfg_master
  import spi_cfg_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input logic clk,
  input logic rst_n,
  spi_cfg_master_if.master bus
);
  if (CLK_DIV < 4 || CLK_DIV > 255) begin : g_bad_div
    $error("spi_cfg_master: CLK_DIV must be within 4..255");
  end
  state_e state;
  logic tick, restart, accept;
  logic [FRAME_BITS-1:0] tx;
  logic [5:0] bit_cnt;
  spi_cfg_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
    .clk(clk),
    .rst_n(rst_n),
    .restart(restart),
    .tick(tick)
  );
`ifdef SPI_CFG_MASTER_READBACK_EN
  assign accept = bus.start;
`else
  assign accept = bus.start && !bus.rw;
`endif
  assign restart = state == IDLE && accept;
  // frame sequencer: SETUP -> 40 high/low bit phases -> HOLD -> GAP, all pins straight from flops
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.sclk <= 1'b0;
      bus.mosi <= 1'b0;
      bus.cs_n <= 1'b1;
      tx <= '0;
      bit_cnt <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          state <= SETUP;
          bus.busy <= 1'b1;
          bus.cs_n <= 1'b0;
          tx <= build_frame(bus.rw, bus.addr, bus.wdata);
          bus.mosi <= bus.rw;
        end
        SETUP: if (tick) begin
          state <= SHIFT;
          bus.sclk <= 1'b1;
          bit_cnt <= 6'(FRAME_BITS - 1);
        end
        SHIFT: if (tick) begin
          if (bus.sclk) begin
            bus.sclk <= 1'b0;
            tx <= {tx[FRAME_BITS-2:0], 1'b0};
            bus.mosi <= tx[FRAME_BITS-2];
          end else if (bit_cnt == 6'd0) state <= HOLD;
          else begin
            bus.sclk <= 1'b1;
            bit_cnt <= bit_cnt - 6'd1;
          end
        end
        HOLD: if (tick) begin
          state <= GAP;
          bus.cs_n <= 1'b1;
        end
        GAP: if (tick) begin
          state <= IDLE;
          bus.busy <= 1'b0;
          bus.done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  // a request that cannot be served is answered with a single err pulse
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) bus.err <= 1'b0;
    else bus.err <= state == IDLE && bus.start && !accept;
`ifdef SPI_CFG_MASTER_READBACK_EN
  logic [1:0] miso_sync;
  logic [DATA_BITS-1:0] rx;
  logic rd_q;
  // synchronize miso, shift in data-byte bits at the end of each high phase, publish at frame end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      miso_sync <= '0;
      rx <= '0;
      rd_q <= 1'b0;
      bus.rdata <= '0;
    end else begin
      miso_sync <= {miso_sync[0], bus.miso};
      if (restart) rd_q <= bus.rw;
      if (state == SHIFT && tick && bus.sclk && bit_cnt < 6'(DATA_BITS)) rx <= {rx[DATA_BITS-2:0], miso_sync[1]};
      if (state == GAP && tick && rd_q) bus.rdata <= rx;
    end
`else
  logic unused_miso;
  assign unused_miso = bus.miso;
  assign bus.rdata = '0;
`endif
endmodule

// File: doc/spi_cfg_master.md
# spi_cfg_master

SPI mode-0 master that issues 40-bit register frames: one command byte followed by four data bytes. It is the initiator-side counterpart of the on-chip SPI slave and memory manager. Test and companion designs use it to write and read back the PWM counter, prescaler, duty-cycle and enable registers through the same `{rw, addr}` + 32-bit framing. It sits between a simple local request/done handshake and the four SPI pins.

## Interface
- `CLK_DIV`, default 4: SCLK half-period in `clk` cycles. Legal range is 4..255; an out-of-range value is an elaboration error.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request. Sampled only while `busy`=0.
- `rw`  in  1  1=read, 0=write. Latched with `start`.
- `addr`  in  7  register address. Latched with `start`.
- `wdata`  in  32  write data. Latched with `start`; ignored for reads.
- `busy`  out  1  frame in progress.
- `done`  out  1  one-cycle pulse at frame completion.
- `err`  out  1  one-cycle pulse when a request is rejected.
- `rdata`  out  32  captured read data. Holds its value until the next completed read.
- `sclk`  out  1  SPI clock. Idles low.
- `mosi`  out  1  master out.
- `cs_n`  out  1  chip select, active low.
- `miso`  in  1  slave out. Asynchronous to this block's sampling.

## Operation
- Frame layout, MSB first: byte0 = `{rw, addr[6:0]}`, then `wdata[31:24]`, `[23:16]`, `[15:8]`, `[7:0]`. Reads transmit `0x00` in the data bytes.
- The master drives MOSI after each SCLK falling edge; the slave samples on the rising edge.
- MISO passes through a 2-flop synchronizer. The synchronized value is sampled on the last `clk` cycle of each SCLK-high phase. Only the 32 data-byte bits are shifted into the read register; the command-byte bits are discarded.
- State machine:
  - IDLE: `cs_n`=1, `sclk`=0. On `start` with `busy`=0, latch the request and go to SETUP.
  - SETUP: `cs_n`=0, `mosi`=bit39. Lasts `CLK_DIV` cycles, then go to SHIFT.
  - SHIFT: 40 bits, each one `CLK_DIV` cycles high followed by `CLK_DIV` cycles low. The next bit is presented on the high-to-low transition. After bit 0's low phase, go to HOLD.
  - HOLD: `sclk`=0, `cs_n`=0. Lasts `CLK_DIV` cycles, then go to GAP.
  - GAP: `cs_n`=1. Lasts `CLK_DIV` cycles, then pulse `done`, load `rdata` if the frame was a read, and return to IDLE.
- `start` while `busy`=1 is ignored. No queuing.
- Reset values: `busy`=0, `done`=0, `err`=0, `rdata`=0, `sclk`=0, `mosi`=0, `cs_n`=1. Asserting reset mid-frame aborts immediately: `cs_n` rises asynchronously, `rdata` clears, and no `done` is issued.

## Timing
- All SPI outputs are driven directly from flops, with no combinational path from inputs.
- Cycle 0 is the cycle in which `start` is sampled.
- `cs_n` and `busy` go low/high at cycle 1.
- The first SCLK rising edge is at cycle 1+`CLK_DIV`.
- `cs_n` rises at cycle 1+82·`CLK_DIV`.
- `done` is high for exactly one cycle at cycle 1+83·`CLK_DIV`. In that same cycle `busy`=0 and `rdata` is valid.
- A `start` asserted in the `done` cycle is accepted, giving back-to-back frames.
- MISO must be stable from 2 `clk` cycles before the end of each high phase. This requires `CLK_DIV`≥4.
- For the default `CLK_DIV`=4, frame latency from `start` to `done` is 333 cycles.

## Configuration
- `SPI_CFG_MASTER_READBACK_EN` defined:
  - Read frames run as described above.
  - The MISO synchronizer and the 32-bit capture shift register are present.
- Not defined:
  - A `start` with `rw`=1 pulses `err` in the following cycle and runs no frame: `busy` stays 0 and `cs_n` stays 1.
  - The synchronizer and capture register are removed, `rdata` is tied to 0, and `miso` is unused.
  - Write frames are unaffected.

## Structure
- Shared package `spi_cfg_pkg` holds:
  - the state enum: IDLE, SETUP, SHIFT, HOLD, GAP;
  - `FRAME_BITS`=40;
  - `CMD_BITS`=8;
  - `RW_BIT`=7;
  - the PWM register address constants, shared with the memory manager.
- One sub-module, `spi_cfg_clkgen`: a half-period down-counter. It issues one-cycle `tick` pulses every `CLK_DIV` cycles and is restarted on frame start.

## Test plan
- Write: `addr`=0x02, `wdata`=0xDEADBEEF, `CLK_DIV`=4.
  - The MOSI bitstream at SCLK rising edges must be 0x02,DE,AD,BE,EF.
  - Exactly 40 SCLK pulses.
  - `done` at cycle 333.
  - `cs_n` low throughout the frame.
- Read with readback enabled: `addr`=0x05, and the slave model returns 0xA5 followed by 0x12345678.
  - `rdata`=0x12345678 at `done`.
  - The MOSI command byte is 0x85.
- Read with readback disabled: `err` pulses at cycle 1, and `busy`, `cs_n` and `sclk` never toggle.
- Busy and back-to-back: pulse `start` again at cycle 50, which must be ignored. Then assert `start` in the `done` cycle.
  - The second frame's `cs_n` falls at `done`+1.
- Reset mid-frame: assert `rst_n`=0 at cycle 100.
  - `cs_n`=1, `sclk`=0 and `rdata`=0 immediately, and no `done`.
  - A fresh write after reset must complete normally.
